// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner with a double-buffered BCD value.
// Latency: an accepted load shows from the next frame start (or from IDLE one cycle after acceptance); outputs are registered.
// Backpressure: load_ready low while the pending buffer holds a value not yet moved to the shadow at a frame end.
// Optional build macro DISPLAY_SCAN_LZB_EN: blank leading zero digits 3..1.
module display_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic [3:0]  digit_code,
    output logic [3:0]  anode_n,
    output logic        frame_tick
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  BLANK      = 4'hF;

    state_t      state, nxt_state;
    logic [15:0] pending, nxt_pending;
    logic        pending_valid, nxt_pending_valid;
    logic [15:0] shadow, nxt_shadow;
    logic        shadow_valid, nxt_shadow_valid;
    logic [15:0] prescaler, nxt_prescaler;
    logic [1:0]  idx, nxt_idx;
    logic        load_acc;
    logic        frame_end;

    assign load_ready = !pending_valid;
    assign load_acc   = load_valid && !pending_valid;
    assign frame_end  = (state == SCAN) && (prescaler == PRESC_LAST) && (idx == 2'd3);

    // Nibble for the decoder; values above 9 pass through so the decoder blanks them.
    function automatic logic [3:0] digit_of(input state_t st, input logic [1:0] i,
                                            input logic [15:0] sh);
        logic [3:0] nib;
        logic       z3, z2, z1;
        logic       lead_zero;
        case (i)
            2'd0:    nib = sh[3:0];
            2'd1:    nib = sh[7:4];
            2'd2:    nib = sh[11:8];
            default: nib = sh[15:12];
        endcase
        z3 = (sh[15:12] == 4'd0);
        z2 = z3 && (sh[11:8] == 4'd0);
        z1 = z2 && (sh[7:4] == 4'd0);
        case (i)
            2'd3:    lead_zero = z3;
            2'd2:    lead_zero = z2;
            2'd1:    lead_zero = z1;
            default: lead_zero = 1'b0;
        endcase
`ifdef DISPLAY_SCAN_LZB_EN
        if (lead_zero) begin
            nib = BLANK;
        end
`else
        if (lead_zero && 1'b0) begin
            nib = BLANK;
        end
`endif
        if (st != SCAN) begin
            nib = BLANK;
        end
        return nib;
    endfunction

    function automatic logic [3:0] anode_of(input state_t st, input logic [1:0] i);
        logic [3:0] a;
        a = 4'b1111;
        if (st == SCAN) begin
            a[i] = 1'b0;
        end
        return a;
    endfunction

    always_comb begin
        nxt_state         = state;
        nxt_pending       = pending;
        nxt_pending_valid = pending_valid;
        nxt_shadow        = shadow;
        nxt_shadow_valid  = shadow_valid;
        nxt_prescaler     = prescaler;
        nxt_idx           = idx;

        case (state)
            IDLE: begin
                if (enable && (pending_valid || shadow_valid)) begin
                    nxt_state     = SCAN;
                    nxt_prescaler = 16'd0;
                    nxt_idx       = 2'd0;
                    if (pending_valid) begin
                        nxt_shadow        = pending;
                        nxt_shadow_valid  = 1'b1;
                        nxt_pending_valid = 1'b0;
                    end
                end
            end
            default: begin
                // A completed frame always hands over pending, even if scanning stops here.
                if (frame_end && pending_valid) begin
                    nxt_shadow        = pending;
                    nxt_shadow_valid  = 1'b1;
                    nxt_pending_valid = 1'b0;
                end
                if (!enable) begin
                    nxt_state     = IDLE;
                    nxt_prescaler = 16'd0;
                    nxt_idx       = 2'd0;
                end else if (prescaler == PRESC_LAST) begin
                    nxt_prescaler = 16'd0;
                    nxt_idx       = idx + 2'd1;
                end else begin
                    nxt_prescaler = prescaler + 16'd1;
                end
            end
        endcase

        // Acceptance needs pending empty, so it never collides with a handover.
        if (load_acc) begin
            nxt_pending       = load_data;
            nxt_pending_valid = 1'b1;
        end
    end

    // Outputs are decoded from the next-state values so they stay registered yet track the state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pending       <= 16'd0;
            pending_valid <= 1'b0;
            shadow        <= 16'd0;
            shadow_valid  <= 1'b0;
            prescaler     <= 16'd0;
            idx           <= 2'd0;
            digit_code    <= BLANK;
            anode_n       <= 4'b1111;
            frame_tick    <= 1'b0;
        end else begin
            state         <= nxt_state;
            pending       <= nxt_pending;
            pending_valid <= nxt_pending_valid;
            shadow        <= nxt_shadow;
            shadow_valid  <= nxt_shadow_valid;
            prescaler     <= nxt_prescaler;
            idx           <= nxt_idx;
            digit_code    <= digit_of(nxt_state, nxt_idx, nxt_shadow);
            anode_n       <= anode_of(nxt_state, nxt_idx);
            frame_tick    <= (nxt_state == SCAN) && (nxt_prescaler == PRESC_LAST)
                             && (nxt_idx == 2'd3);
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a per-cycle expected-output scoreboard.
module tb_display_scan_ctrl;

    localparam int SCAN_DIV = 4;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic [3:0]  digit_code;
    logic [3:0]  anode_n;
    logic        frame_tick;

    typedef struct packed {
        logic [3:0] anode;
        logic [3:0] digit;
        logic       tick;
    } exp_t;

    exp_t  q[$];
    int    n_assert = 0;
    int    n_fail   = 0;
    int    n_cyc    = 0;
    string phase    = "init";

    display_scan_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .digit_code (digit_code),
        .anode_n    (anode_n),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] exp_digit(input logic [15:0] d, input int i);
        logic [15:0] sh;
        logic [3:0]  nib;
        sh  = d >> (4 * i);
        nib = sh[3:0];
`ifdef DISPLAY_SCAN_LZB_EN
        if (i > 0 && sh == 16'd0) nib = 4'hF;
`endif
        return nib;
    endfunction

    task automatic push_idle();
        exp_t e;
        e.anode = 4'b1111;
        e.digit = 4'hF;
        e.tick  = 1'b0;
        q.push_back(e);
    endtask

    task automatic push_cycles(input logic [15:0] d, input int first, input int count);
        exp_t e;
        for (int c = first; c < first + count; c++) begin
            e.anode = ~(4'b0001 << (c / SCAN_DIV));
            e.digit = exp_digit(d, c / SCAN_DIV);
            e.tick  = (c == 4 * SCAN_DIV - 1);
            q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n_cyc++;
    endtask

    task automatic check_out();
        exp_t e;
        n_assert++;
        assert (q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s scoreboard_empty got 0 entries want >=1", phase);
        end
        if (q.size() != 0) begin
            e = q.pop_front();
            n_assert++;
            assert (anode_n === e.anode) else begin
                n_fail++;
                $error("FAIL %s@%0d anode_n got %b want %b", phase, n_cyc, anode_n, e.anode);
            end
            n_assert++;
            assert (digit_code === e.digit) else begin
                n_fail++;
                $error("FAIL %s@%0d digit_code got %h want %h", phase, n_cyc, digit_code, e.digit);
            end
            n_assert++;
            assert (frame_tick === e.tick) else begin
                n_fail++;
                $error("FAIL %s@%0d frame_tick got %b want %b", phase, n_cyc, frame_tick, e.tick);
            end
        end
    endtask

    task automatic chk_ready(input logic want);
        n_assert++;
        assert (load_ready === want) else begin
            n_fail++;
            $error("FAIL %s@%0d load_ready got %b want %b", phase, n_cyc, load_ready, want);
        end
    endtask

    task automatic scan(input int n);
        for (int k = 0; k < n; k++) begin
            check_out();
            step();
        end
    endtask

    // Shows one full frame of 'shown' while loading 'nxt' on its first cycle.
    task automatic frame_with_load(input logic [15:0] shown, input logic [15:0] nxt);
        push_cycles(shown, 0, 4 * SCAN_DIV);
        load_valid = 1'b1;
        load_data  = nxt;
        scan(1);
        load_valid = 1'b0;
        chk_ready(1'b0);
        scan(4 * SCAN_DIV - 1);
    endtask

    initial begin
        rst_n      = 1'b1;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0000;
        #2 rst_n = 1'b0;
        #1;
        phase = "reset";
        push_idle();
        check_out();
        chk_ready(1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        enable = 1'b1;

        phase = "idle_noload";
        for (int k = 0; k < 6; k++) begin
            push_idle();
            check_out();
            chk_ready(1'b1);
            step();
        end

        phase = "load_1234";
        load_valid = 1'b1;
        load_data  = 16'h1234;
        step();
        load_valid = 1'b0;
        chk_ready(1'b0);
        push_idle();
        check_out();
        step();
        chk_ready(1'b1);
        push_cycles(16'h1234, 0, 4 * SCAN_DIV);
        scan(4 * SCAN_DIV);

        phase = "midframe_5678";
        push_cycles(16'h1234, 0, 4 * SCAN_DIV);
        scan(5);
        load_valid = 1'b1;
        load_data  = 16'h5678;
        chk_ready(1'b1);
        scan(1);
        load_data = 16'h9ABC;
        chk_ready(1'b0);
        scan(4 * SCAN_DIV - 7);
        chk_ready(1'b0);
        scan(1);
        chk_ready(1'b1);
        push_cycles(16'h5678, 0, 4 * SCAN_DIV);
        scan(1);
        load_valid = 1'b0;
        chk_ready(1'b0);
        scan(4 * SCAN_DIV - 1);

        phase = "enable_drop";
        push_cycles(16'h9ABC, 0, 2 * SCAN_DIV + 2);
        scan(2 * SCAN_DIV + 2);
        enable = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            push_idle();
            check_out();
            step();
        end
        enable = 1'b1;
        push_idle();
        check_out();
        step();
        push_cycles(16'h9ABC, 0, 4 * SCAN_DIV);
        scan(4 * SCAN_DIV);

        phase = "lzb";
        frame_with_load(16'h9ABC, 16'h0007);
        frame_with_load(16'h0007, 16'h0107);
        frame_with_load(16'h0107, 16'h0000);

        phase = "reset_midframe";
        push_cycles(16'h0000, 0, 6);
        load_valid = 1'b1;
        load_data  = 16'h4321;
        scan(1);
        load_valid = 1'b0;
        chk_ready(1'b0);
        scan(5);
        #2 rst_n = 1'b0;
        #1;
        push_idle();
        check_out();
        chk_ready(1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        phase = "after_reset";
        for (int k = 0; k < 6; k++) begin
            push_idle();
            check_out();
            chk_ready(1'b1);
            step();
        end

        phase = "drain";
        n_assert++;
        assert (q.size() == 0) else begin
            n_fail++;
            $error("FAIL %s leftover_entries got %0d want 0", phase, q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 4, clock cycles each digit is driven (legal range 2..65535).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  high = scanning permitted; low = display blanked.
REQ-005 load_valid  input  1  new 4-digit BCD value offered.
REQ-006 load_data  input  16  digits, [3:0] = digit 0 (least significant) .. [15:12] = digit 3.
REQ-007 load_ready  output  1  high when the pending buffer is empty; a load is accepted on an edge with load_valid && load_ready.
REQ-008 digit_code  output  4  nibble for the shared 7-segment decoder; 4'hF = blank, which the decoder maps to all segments off.
REQ-009 anode_n  output  4  digit select, active-low, one-hot-low in SCAN, 4'b1111 otherwise.
REQ-010 frame_tick  output  1  one-cycle pulse at each frame end.

Function
REQ-011 Registers: pending (16b) + pending_valid, shadow (16b) + shadow_valid, prescaler (16b), idx (2b), state {IDLE, SCAN}.
REQ-012 load_ready SHALL equal !pending_valid; an accepted load writes pending and sets pending_valid.
REQ-013 IDLE -> SCAN when enable && (pending_valid || shadow_valid); on this transition pending, if valid, SHALL be copied to shadow and pending_valid cleared; idx=0, prescaler=0.
REQ-014 SCAN -> IDLE on any edge with enable low; prescaler and idx cleared; pending and shadow contents retained.
REQ-015 In SCAN the prescaler counts 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps to 0 and idx increments, 3 wrapping to 0.
REQ-016 Frame end = prescaler at SCAN_DIV-1 with idx==3; at that edge frame_tick is high for that cycle, and if pending_valid then shadow<=pending, shadow_valid<=1, pending_valid<=0.
REQ-017 A load accepted on a frame-end edge while pending was empty SHALL land in pending and transfer at the next frame end, not the current one.
REQ-018 In SCAN, anode_n[idx]=0, others 1; digit_code = shadow nibble idx (subject to REQ-025).
REQ-019 In IDLE, anode_n=4'b1111, digit_code=4'hF, frame_tick=0.
REQ-020 Outputs are combinational functions of the registered state only; no input-to-output combinational path except load_ready from pending_valid.
REQ-021 Shadow nibbles >9 SHALL pass through unchanged (the decoder blanks them).

Reset
REQ-022 While rst_n=0: state=IDLE, pending_valid=0, shadow_valid=0, pending=shadow=0, prescaler=0, idx=0.
REQ-023 Output reset values: load_ready=1, digit_code=4'hF, anode_n=4'b1111, frame_tick=0.
REQ-024 Reset asserted mid-frame SHALL take effect immediately and discard pending and shadow data.

Configuration
REQ-025 Macro DISPLAY_SCAN_LZB_EN defined: in SCAN, digit i (i=3..1) SHALL show 4'hF if it and all higher digits of shadow are 0; digit 0 is never blanked. Undefined: all digits display their nibble, leading zeros shown.

Verification
REQ-026 Reset release, enable=1, no load -> stays IDLE; anode_n=1111, digit_code=F, load_ready=1 indefinitely.
REQ-027 Load 16'h1234 in IDLE, enable=1, SCAN_DIV=4 -> anode_n 1110/1101/1011/0111 for 4 cycles each with digit_code 4,3,2,1; frame_tick on the 16th scan cycle.
REQ-028 Mid-frame load 16'h5678 during frame showing 1234 -> load_ready low until frame end; next frame shows 8,7,6,5; second load held off while pending full.
REQ-029 enable dropped during digit 2 -> next cycle anode_n=1111, digit_code=F; enable reasserted -> restart at digit 0 with retained shadow.
REQ-030 Load 16'h0007: without DISPLAY_SCAN_LZB_EN codes 7,0,0,0; with it 7,F,F,F; load 16'h0000 with it -> 0,F,F,F.
REQ-031 rst_n pulsed low mid-frame with pending full -> outputs at reset values asynchronously; IDLE with no data afterwards.
